cmd_decoder_mc: RTL and testbench

CMD_DECODER_MC -- requirements
Module: cmd_decoder_mc

---
 rtl/cmd_pkg.sv | 42 ++++
 rtl/cmd_char_classify.sv | 34 +++
 rtl/cmd_decoder_mc.sv | 158 +++++++++++++++
 tb/tb_cmd_decoder_mc.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared types and ASCII constants for the serial command decoder.
// Consumed by cmd_char_classify and cmd_decoder_mc.
package cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_ECHO = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_RUN    = 3'd0,
    CLS_CLEAR  = 3'd1,
    CLS_MODE   = 3'd2,
    CLS_STOP   = 3'd3,
    CLS_DIGIT  = 3'd4,
    CLS_ALL    = 3'd5,
    CLS_IGNORE = 3'd6,
    CLS_BAD    = 3'd7
  } cmd_class_e;

  localparam logic [7:0] CH_R    = 8'h72;
  localparam logic [7:0] CH_C    = 8'h63;
  localparam logic [7:0] CH_M    = 8'h6D;
  localparam logic [7:0] CH_X    = 8'h78;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  // Folds 'A'..'Z' onto 'a'..'z'; every other byte passes through.
  function automatic logic [7:0] to_lower(input logic [7:0] c);
    logic [7:0] r;
    if (c >= 8'h41 && c <= 8'h5A) begin
      r = c | 8'h20;
    end else begin
      r = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmd_char_classify.sv
// Combinational byte classifier: command class plus digit value.
// The digit value is meaningful only when the class is CLS_DIGIT.
module cmd_char_classify
  import cmd_pkg::*;
(
  input  logic [7:0] data_i,
  output cmd_class_e cls_o,
  output logic [2:0] digit_o
);

  logic [7:0] lc_s;

  // Map one byte to its command class
  always_comb begin
    lc_s    = to_lower(data_i);
    digit_o = lc_s[2:0];
    cls_o   = CLS_BAD;
    if (lc_s >= CH_ZERO && lc_s <= (CH_ZERO + 8'd7)) begin
      cls_o = CLS_DIGIT;
    end else begin
      case (lc_s)
        CH_R:    cls_o = CLS_RUN;
        CH_C:    cls_o = CLS_CLEAR;
        CH_M:    cls_o = CLS_MODE;
        CH_X:    cls_o = CLS_STOP;
        CH_STAR: cls_o = CLS_ALL;
        CH_CR:   cls_o = CLS_IGNORE;
        CH_LF:   cls_o = CLS_IGNORE;
        default: cls_o = CLS_BAD;
      endcase
    end
  end

endmodule

// File: rtl/cmd_decoder_mc.sv
// Byte-command decoder driving NUM_CH counter-channel controls from an RX FIFO.
// Define CMD_ECHO_EN to echo every popped byte to the TX FIFO.
module cmd_decoder_mc
  import cmd_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_empty,
  input  logic [7:0]        rx_rdata,
  output logic              rx_pop,
  input  logic              tx_full,
  output logic              tx_push,
  output logic [7:0]        tx_wdata,
  output logic [NUM_CH-1:0] run_en,
  output logic [NUM_CH-1:0] clear_pulse,
  output logic [NUM_CH-1:0] mode,
  output logic [2:0]        sel_ch,
  output logic              sel_all,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [3:0]       NUM_CH_L = 4'(NUM_CH);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] run_en_q, run_en_d;
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] clear_q, clear_d;
  logic [NUM_CH-1:0] tgt_s;
  logic [2:0]        sel_ch_q, sel_ch_d;
  logic              sel_all_q, sel_all_d;
  logic [ERR_W-1:0]  err_q, err_d, err_sat_s;
  logic [7:0]        tx_wdata_q, tx_wdata_d;
  cmd_class_e        cls_s;
  logic [2:0]        dig_s;

`ifndef CMD_ECHO_EN
  logic unused_tx_full_s;
  assign unused_tx_full_s = tx_full;
`endif

  cmd_char_classify u_classify (
    .data_i  (rx_rdata),
    .cls_o   (cls_s),
    .digit_o (dig_s)
  );

  // Sequencing: pop in IDLE, decode in READ, optional echo handshake
  always_comb begin
    state_d = state_q;
    rx_pop  = 1'b0;
    tx_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rst_n gate keeps the strobe low while reset is held
        if (!rx_empty && rst_n) begin
          rx_pop  = 1'b1;
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef CMD_ECHO_EN
      ST_READ: state_d = ST_ECHO;
      ST_ECHO: begin
        if (!tx_full) begin
          tx_push = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ECHO;
        end
      end
`else
      ST_READ: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Channels addressed by r/c/m under the current selection
  always_comb begin
    tgt_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_s[i] = sel_all_q || (sel_ch_q == 3'(i));
    end
    err_sat_s = (err_q == '1) ? err_q : (err_q + ERR_ONE);
  end

  // Command decode; results register at the end of READ
  always_comb begin
    run_en_d   = run_en_q;
    mode_d     = mode_q;
    clear_d    = '0;
    sel_ch_d   = sel_ch_q;
    sel_all_d  = sel_all_q;
    err_d      = err_q;
    tx_wdata_d = tx_wdata_q;
    if (state_q == ST_READ) begin
`ifdef CMD_ECHO_EN
      tx_wdata_d = rx_rdata;
`endif
      case (cls_s)
        CLS_RUN:    run_en_d  = run_en_q ^ tgt_s;
        CLS_CLEAR:  clear_d   = tgt_s;
        CLS_MODE:   mode_d    = mode_q ^ tgt_s;
        CLS_STOP:   run_en_d  = '0;
        CLS_ALL:    sel_all_d = 1'b1;
        CLS_IGNORE: err_d     = err_q;
        CLS_DIGIT: begin
          if ({1'b0, dig_s} < NUM_CH_L) begin
            sel_ch_d  = dig_s;
            sel_all_d = 1'b0;
          end else begin
            err_d = err_sat_s;
          end
        end
        default:    err_d     = err_sat_s;
      endcase
    end else begin
      clear_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      run_en_q   <= '0;
      mode_q     <= '0;
      clear_q    <= '0;
      sel_ch_q   <= 3'd0;
      sel_all_q  <= 1'b0;
      err_q      <= '0;
      tx_wdata_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      run_en_q   <= run_en_d;
      mode_q     <= mode_d;
      clear_q    <= clear_d;
      sel_ch_q   <= sel_ch_d;
      sel_all_q  <= sel_all_d;
      err_q      <= err_d;
      tx_wdata_q <= tx_wdata_d;
    end
  end

  assign run_en      = run_en_q;
  assign mode        = mode_q;
  assign clear_pulse = clear_q;
  assign sel_ch      = sel_ch_q;
  assign sel_all     = sel_all_q;
  assign err_cnt     = err_q;
  assign tx_wdata    = tx_wdata_q;

endmodule

// File: tb/tb_cmd_decoder_mc.sv
// Scoreboard bench for cmd_decoder_mc: a FIFO model feeds bytes, a reference
// model queues expected outputs, compared when they become due.
module tb_cmd_decoder_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_empty;
  logic [7:0] rx_rdata;
  logic       tx_full;

  logic       rx_pop, tx_push, sel_all;
  logic [7:0] tx_wdata, err_cnt;
  logic [3:0] run_en, clear_pulse, mode;
  logic [2:0] sel_ch;

  logic       rx_pop2, tx_push2, sel_all2;
  logic [7:0] tx_wdata2;
  logic [1:0] err2;
  logic [3:0] run_en2, clear2, mode2;
  logic [2:0] sel_ch2;

  always #5 clk = ~clk;

  cmd_decoder_mc #(.NUM_CH(4), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty), .rx_rdata(rx_rdata),
    .rx_pop(rx_pop), .tx_full(tx_full), .tx_push(tx_push), .tx_wdata(tx_wdata),
    .run_en(run_en), .clear_pulse(clear_pulse), .mode(mode), .sel_ch(sel_ch),
    .sel_all(sel_all), .err_cnt(err_cnt)
  );

  cmd_decoder_mc #(.NUM_CH(4), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty), .rx_rdata(rx_rdata),
    .rx_pop(rx_pop2), .tx_full(tx_full), .tx_push(tx_push2), .tx_wdata(tx_wdata2),
    .run_en(run_en2), .clear_pulse(clear2), .mode(mode2), .sel_ch(sel_ch2),
    .sel_all(sel_all2), .err_cnt(err2)
  );

  typedef struct {
    int         due;
    logic [3:0] run;
    logic [3:0] mde;
    logic [3:0] clr;
    logic [2:0] sel;
    logic       sall;
    logic [7:0] err;
    logic [1:0] err2;
  } exp_t;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         pop_cnt = 0;
  int         echo_cnt = 0;
  int         clr_zero_cyc = -1;
  logic [7:0] fifo[$];
  logic [7:0] echoq[$];
  exp_t       expq[$];
  logic [3:0] m_run, m_mode;
  logic [2:0] m_sel;
  logic       m_all;
  logic [7:0] m_err;
  logic [1:0] m_err2;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_run = 4'h0; m_mode = 4'h0; m_sel = 3'd0; m_all = 1'b0;
    m_err = 8'h00; m_err2 = 2'b00;
    expq.delete(); echoq.delete(); clr_zero_cyc = -1;
  endtask

  // Reference decode of one popped byte; result due two cycles after the pop
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] lb;
    logic [3:0] tgt, clr;
    exp_t       e;
    lb  = (b >= 8'h41 && b <= 8'h5A) ? (b + 8'h20) : b;
    tgt = m_all ? 4'hF : (4'b0001 << m_sel);
    clr = 4'h0;
    case (lb)
      8'h72: m_run  = m_run ^ tgt;
      8'h63: clr    = tgt;
      8'h6D: m_mode = m_mode ^ tgt;
      8'h78: m_run  = 4'h0;
      8'h2A: m_all  = 1'b1;
      8'h0D, 8'h0A: ;
      8'h30, 8'h31, 8'h32, 8'h33: begin
        m_sel = lb[2:0];
        m_all = 1'b0;
      end
      default: begin
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
        if (m_err2 != 2'b11) m_err2 = m_err2 + 2'd1;
      end
    endcase
    e.due = cyc + 2; e.run = m_run; e.mde = m_mode; e.clr = clr;
    e.sel = m_sel; e.sall = m_all; e.err = m_err; e.err2 = m_err2;
    expq.push_back(e);
    echoq.push_back(b);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
    rx_empty = 1'b0;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) push_byte(s[i]);
  endtask

  // One clock: monitor and compare at negedge, update FIFO model after posedge
  task automatic cycle();
    logic [7:0] b;
    logic       popped;
    exp_t       e;
    popped = 1'b0;
    b = 8'h00;
    @(negedge clk);
    if (rx_pop || rx_pop2) check("pop_lockstep", rx_pop2, rx_pop);
    if (rx_pop) begin
      check("pop_when_empty", fifo.size() == 0, 0);
      if (fifo.size() > 0) begin
        b = fifo.pop_front();
        model_byte(b);
        popped = 1'b1;
        pop_cnt++;
      end
    end
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      check("run_en", run_en, e.run);
      check("mode", mode, e.mde);
      check("clear_pulse", clear_pulse, e.clr);
      check("sel_ch", sel_ch, e.sel);
      check("sel_all", sel_all, e.sall);
      check("err_cnt", err_cnt, e.err);
      check("err_cnt_w2", err2, e.err2);
      check("dut2_ctrl", {run_en2, mode2, clear2, sel_ch2, sel_all2},
            {e.run, e.mde, e.clr, e.sel, e.sall});
      if (e.clr != 4'h0) clr_zero_cyc = cyc + 1;
    end else if (cyc == clr_zero_cyc) begin
      check("clear_one_cycle", clear_pulse, 4'h0);
    end
`ifdef CMD_ECHO_EN
    if (tx_push) begin
      if (echoq.size() > 0) check("echo_data", tx_wdata, echoq.pop_front());
      else check("echo_extra", 1, 0);
      echo_cnt++;
      check("echo_lockstep", {tx_push2, tx_wdata2}, {tx_push, tx_wdata});
    end
`else
    if (popped) check("no_echo", {tx_push, tx_wdata, tx_push2, tx_wdata2}, 0);
    echoq.delete();
`endif
    @(posedge clk);
    cyc++;
    #1;
    if (popped) rx_rdata = b;
    rx_empty = (fifo.size() == 0);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((fifo.size() > 0 || expq.size() > 0 || echoq.size() > 0) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) check("settle_timeout", 1, 0);
    repeat (2) cycle();
  endtask

  task automatic wait_pop();
    int n, pc;
    n = 0;
    pc = pop_cnt;
    while (pop_cnt == pc && n < 50) begin
      cycle();
      n++;
    end
    if (n >= 50) check("pop_timeout", 1, 0);
  endtask

  initial begin
    int pc, ec;
    rst_n = 1'b0; rx_empty = 1'b1; rx_rdata = 8'h00; tx_full = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {run_en, mode, clear_pulse, sel_ch, sel_all, err_cnt}, 0);
    check("rst_fifo", {rx_pop, tx_push, tx_wdata, err2}, 0);
    rst_n = 1'b1;

    push_str("2r"); settle();
    check("sel2_run", {run_en, sel_ch}, {4'b0100, 3'd2});
    push_str("*M"); settle();
    check("bcast_mode", {mode, sel_all}, {4'b1111, 1'b1});
    push_str("1m"); settle();
    check("sel1_mode", {mode, sel_all}, {4'b1101, 1'b0});
    push_str("3c"); settle();
    push_str("x"); settle();
    check("stop_all", run_en, 4'h0);
    push_str("5Q"); push_byte(8'h0A); push_byte(8'h0D); settle();
    check("bad_bytes", {err_cnt, sel_ch}, {8'd2, 3'd3});
    push_str("zz~"); settle();
    check("err_sat_w2", {err_cnt, err2}, {8'd5, 2'b11});
    push_str("cc"); settle();
    push_str("*rC"); settle();
    push_str("0R7m"); settle();

`ifdef CMD_ECHO_EN
    tx_full = 1'b1;
    push_str("rm");
    wait_pop();
    pc = pop_cnt;
    ec = echo_cnt;
    repeat (12) cycle();
    check("stall_no_pop", pop_cnt - pc, 0);
    check("stall_no_push", echo_cnt - ec, 0);
    tx_full = 1'b0;
    cycle();
    check("stall_release", echo_cnt - ec, 1);
    settle();
`else
    tx_full = 1'b1;
    push_str("rm"); settle();
    tx_full = 1'b0;
`endif

    model_reset();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    push_str("0r1r"); settle();
    check("pre_rst_run", run_en, 4'b0011);
    push_str("rm");
    wait_pop();
    rst_n = 1'b0;
    #1;
    check("midread_rst_ctrl", {run_en, mode, clear_pulse, sel_ch, sel_all, err_cnt}, 0);
    check("midread_rst_pop", {rx_pop, tx_push, tx_wdata}, 0);
    model_reset();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    settle();
    check("post_rst_next_byte", {run_en, mode}, {4'b0000, 4'b0001});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
